timer_counter: RTL and testbench

- Memory-mapped programmable timer that occupies device slot 0 (address window 0x0000_7F00–0x0000_7F0F) behind the system bridge.
- Receives the bridge's device address, write data and slot-0 write enable. Returns read data combinationally on the slot-0 read-data input.
- Raises an interrupt request to the CP0/exception unit when its count expires.

---
 rtl/timer_counter_pkg.sv | 46 ++++
 rtl/timer_counter_if.sv | 27 ++
 rtl/timer_counter.sv | 104 ++++++++++
 tb/tb_timer_counter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/timer_counter_pkg.sv
// Shared definitions for the slot-0 programmable timer: register offsets,
// mode encodings, FSM states and the device base address used by the bridge.
package timer_counter_pkg;

  localparam int TC_DATA_W = 32;
  localparam int TC_ADDR_W = 30;

  // Byte-address bits [15:4] of the timer window 0x0000_7F00-0x0000_7F0F
  localparam logic [11:0] TC_BASE_ADDR = 12'h7F0;

  // Word offsets decoded from Addr[1:0]
  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CNT,
    ST_INT
  } tc_state_e;

  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } tc_ctrl_t;

  // Reserved modes 10/11 fall back to one-shot behaviour
  function automatic logic tc_is_reload(input logic [1:0] mode);
    case (mode)
      MODE_RELOAD:  return 1'b1;
      MODE_ONESHOT: return 1'b0;
      default:      return 1'b0;
    endcase
  endfunction

  // Bridge-side decode of a full byte address into the timer window
  function automatic logic tc_dev_hit(input logic [31:0] byte_addr);
    return byte_addr[31:4] == {16'h0000, TC_BASE_ADDR};
  endfunction

endpackage

// File: rtl/timer_counter_if.sv
// Bridge <-> timer slot-0 bus: word address, write strobe/data, read data, IRQ.
interface timer_counter_if;
  import timer_counter_pkg::*;

  logic [TC_ADDR_W-1:0] Addr;
  logic                 WE;
  logic [TC_DATA_W-1:0] Din;
  logic [TC_DATA_W-1:0] Dout;
  logic                 IRQ;

  modport master (
    output Addr,
    output WE,
    output Din,
    input  Dout,
    input  IRQ
  );

  modport slave (
    input  Addr,
    input  WE,
    input  Din,
    output Dout,
    output IRQ
  );

endinterface

// File: rtl/timer_counter.sv
// Programmable down-counting timer on device slot 0. CTRL/PRESET/COUNT
// register file, four-state counting FSM and a zero-latency read mux.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  timer_counter_if.slave  bus
);

  tc_ctrl_t             r_ctrl;
  logic [CNT_W-1:0]     r_preset;
  logic [CNT_W-1:0]     r_count;
  tc_state_e            r_state;
  logic                 r_irq_pending;

  logic                 w_wr_ctrl;
  logic                 w_wr_preset;
  logic [TC_DATA_W-1:0] w_rdata;

  assign w_wr_ctrl   = bus.WE && (bus.Addr[1:0] == TC_CTRL);
  assign w_wr_preset = bus.WE && (bus.Addr[1:0] == TC_PRESET);

  // Register file, counting FSM and interrupt-pending flag share one block so
  // host writes and FSM-side updates of CTRL.Enable resolve in one place.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl        <= '0;
      r_preset      <= '0;
      r_count       <= '0;
      r_state       <= ST_IDLE;
      r_irq_pending <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_ctrl <= tc_ctrl_t'(bus.Din[3:0]);
      end
      if (w_wr_preset) begin
        r_preset <= CNT_W'(bus.Din);
      end

      // Setting from INT beats a same-cycle CTRL-write clear; in auto-reload
      // the flag lives for exactly one cycle.
      if (r_state == ST_INT) begin
        r_irq_pending <= 1'b1;
      end else if (w_wr_ctrl) begin
        r_irq_pending <= 1'b0;
      end else if (tc_is_reload(r_ctrl.mode)) begin
        r_irq_pending <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (r_ctrl.en) begin
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_count <= r_preset;
          r_state <= ST_CNT;
        end
        ST_CNT: begin
          if (!r_ctrl.en) begin
            r_state <= ST_IDLE;
          end else if (r_count == '0) begin
            r_state <= ST_INT;
          end else begin
            r_count <= r_count - CNT_W'(1);
          end
        end
        ST_INT: begin
          if (tc_is_reload(r_ctrl.mode)) begin
            r_state <= ST_LOAD;
          end else begin
            // A host CTRL write in this cycle keeps its own Enable value
            if (!w_wr_ctrl) begin
              r_ctrl.en <= 1'b0;
            end
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Zero-latency read mux; offset 0xC and CTRL[31:4] read as zero
  always_comb begin
    w_rdata = '0;
    case (bus.Addr[1:0])
      TC_CTRL:   w_rdata = {{(TC_DATA_W-4){1'b0}}, r_ctrl};
      TC_PRESET: w_rdata = TC_DATA_W'(r_preset);
      TC_COUNT:  w_rdata = TC_DATA_W'(r_count);
      default:   w_rdata = '0;
    endcase
  end

  assign bus.Dout = w_rdata;
  assign bus.IRQ  = r_ctrl.im & r_irq_pending;

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: the stimulus process drives one bus
// cycle per call and queues the expected Dout/IRQ for checked reads; a
// negedge monitor pops and compares.
module tb_timer_counter;
  import timer_counter_pkg::*;

  logic clk;
  logic reset;
  logic chk_en;

  timer_counter_if bus ();

  timer_counter #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  string       q_name[$];
  logic [31:0] q_d[$];
  logic        q_irq[$];

  int n_pass  = 0;
  int n_total = 0;

  string       m_name;
  logic [31:0] m_d;
  logic        m_irq;

  // Monitor: compare whenever the stimulus marks the current cycle as checked
  always @(negedge clk) begin
    if (chk_en) begin
      if (q_d.size() == 0) begin
        n_total = n_total + 1;
        $display("FAIL scoreboard: read strobe with empty queue, got Dout=%h IRQ=%b required an entry",
                 bus.Dout, bus.IRQ);
      end else begin
        m_name = q_name.pop_front();
        m_d    = q_d.pop_front();
        m_irq  = q_irq.pop_front();
        n_total = n_total + 1;
        if (bus.Dout === m_d) n_pass = n_pass + 1;
        else $display("FAIL %s Dout: got %h required %h", m_name, bus.Dout, m_d);
        n_total = n_total + 1;
        if (bus.IRQ === m_irq) n_pass = n_pass + 1;
        else $display("FAIL %s IRQ: got %b required %b", m_name, bus.IRQ, m_irq);
      end
    end
  end

  function automatic logic [29:0] waddr(input logic [1:0] off);
    return {16'h0000, TC_BASE_ADDR, off};
  endfunction

  task automatic step(input logic we, input logic [1:0] off, input logic [31:0] din,
                      input logic chk, input logic [31:0] exp_d, input logic exp_irq,
                      input string nm);
    bus.WE   = we;
    bus.Addr = waddr(off);
    bus.Din  = din;
    chk_en   = chk;
    if (chk) begin
      q_name.push_back(nm);
      q_d.push_back(exp_d);
      q_irq.push_back(exp_irq);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] off, input logic [31:0] exp_d, input logic exp_irq,
                    input string nm);
    step(1'b0, off, 32'h0, 1'b1, exp_d, exp_irq, nm);
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] din);
    step(1'b1, off, din, 1'b0, 32'h0, 1'b0, "");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1);
  end

  initial begin
    int cnt_os [8]  = '{0, 0, 3, 2, 1, 0, 0, 0};
    bit irq_os [8]  = '{0, 0, 0, 0, 0, 0, 0, 1};
    int cnt_ar [13] = '{0, 0, 2, 1, 0, 0, 0, 2, 1, 0, 0, 0, 2};
    bit irq_ar [13] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
    int cnt_mk [10] = '{0, 0, 5, 4, 3, 2, 1, 0, 0, 0};
    int cnt_re [10] = '{3, 3, 5, 4, 3, 2, 1, 0, 0, 0};
    bit irq_re [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    int cnt_p0 [5]  = '{5, 5, 0, 0, 0};
    bit irq_p0 [5]  = '{0, 0, 0, 0, 1};
    int cnt_co [6]  = '{0, 0, 3, 2, 1, 0};

    chk_en   = 1'b0;
    // Reset held two cycles while the bus tries to write all ones
    reset    = 1'b1;
    bus.WE   = 1'b1;
    bus.Din  = 32'hFFFF_FFFF;
    bus.Addr = waddr(TC_CTRL);
    @(posedge clk);
    #1;
    bus.Addr = waddr(TC_PRESET);
    @(posedge clk);
    #1;
    reset = 1'b0;

    rd(2'd0, 32'h0, 1'b0, "rst_ctrl");
    rd(2'd1, 32'h0, 1'b0, "rst_preset");
    rd(2'd2, 32'h0, 1'b0, "rst_count");
    rd(2'd3, 32'h0, 1'b0, "rst_0xC");

    // One-shot, PRESET=3: IRQ after E+7, Enable self-clears
    wr(TC_PRESET, 32'd3);
    wr(TC_CTRL, 32'h9);
    for (int i = 0; i < 8; i++) rd(TC_COUNT, 32'(cnt_os[i]), irq_os[i], $sformatf("oneshot_cnt%0d", i));
    rd(TC_CTRL, 32'h8, 1'b1, "oneshot_ctrl_en_clr");
    rd(TC_CTRL, 32'h8, 1'b1, "oneshot_irq_hold");
    wr(TC_CTRL, 32'h0);
    rd(TC_CTRL, 32'h0, 1'b0, "oneshot_irq_clr");

    // Auto-reload, PRESET=2: one-cycle pulses after E+6 and E+11
    wr(TC_PRESET, 32'd2);
    wr(TC_CTRL, 32'hB);
    for (int i = 0; i < 13; i++) rd(TC_COUNT, 32'(cnt_ar[i]), irq_ar[i], $sformatf("reload_cnt%0d", i));
    wr(TC_CTRL, 32'h0);
    rd(TC_COUNT, 32'h0, 1'b0, "reload_stop0");
    rd(TC_COUNT, 32'h0, 1'b0, "reload_stop1");

    // Masked one-shot, PRESET=5: expiry never reaches IRQ
    wr(TC_PRESET, 32'd5);
    wr(TC_CTRL, 32'h1);
    for (int i = 0; i < 10; i++) rd(TC_COUNT, 32'(cnt_mk[i]), 1'b0, $sformatf("mask_cnt%0d", i));
    rd(TC_CTRL, 32'h0, 1'b0, "mask_ctrl");

    // Stop mid-count: Enable cleared at the edge that makes COUNT 3
    wr(TC_CTRL, 32'h1);
    rd(TC_COUNT, 32'd0, 1'b0, "stop_cnt0");
    rd(TC_COUNT, 32'd0, 1'b0, "stop_cnt1");
    rd(TC_COUNT, 32'd5, 1'b0, "stop_cnt2");
    wr(TC_CTRL, 32'h0);
    rd(TC_COUNT, 32'd3, 1'b0, "stop_frozen0");
    rd(TC_COUNT, 32'd3, 1'b0, "stop_frozen1");
    rd(TC_COUNT, 32'd3, 1'b0, "stop_frozen2");

    // Re-enable reloads from PRESET and runs to an unmasked expiry
    wr(TC_CTRL, 32'h9);
    for (int i = 0; i < 10; i++) rd(TC_COUNT, 32'(cnt_re[i]), irq_re[i], $sformatf("reen_cnt%0d", i));
    wr(TC_CTRL, 32'h0);
    rd(TC_CTRL, 32'h0, 1'b0, "reen_clr");

    // Register edges
    wr(TC_COUNT, 32'h1234);
    rd(TC_COUNT, 32'h0, 1'b0, "count_ro");
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, 32'h0, 1'b0, "off_c_zero");
    rd(TC_PRESET, 32'd5, 1'b0, "preset_rb");
    wr(TC_CTRL, 32'hFFFF_FFFF);
    rd(TC_CTRL, 32'hF, 1'b0, "ctrl_upper_masked");
    wr(TC_CTRL, 32'h0);
    rd(TC_CTRL, 32'h0, 1'b0, "ctrl_off");
    rd(TC_COUNT, 32'd5, 1'b0, "ctrl_off_cnt");

    // PRESET=0 one-shot: minimum latency, IRQ after E+4
    wr(TC_PRESET, 32'd0);
    wr(TC_CTRL, 32'h9);
    for (int i = 0; i < 5; i++) rd(TC_COUNT, 32'(cnt_p0[i]), irq_p0[i], $sformatf("p0_cnt%0d", i));
    rd(TC_CTRL, 32'h8, 1'b1, "p0_ctrl");
    wr(TC_CTRL, 32'h0);
    rd(TC_CTRL, 32'h0, 1'b0, "p0_clr");

    // Collision: host writes CTRL=0x9 on the INT edge
    wr(TC_PRESET, 32'd3);
    wr(TC_CTRL, 32'h9);
    for (int i = 0; i < 6; i++) rd(TC_COUNT, 32'(cnt_co[i]), 1'b0, $sformatf("coll_cnt%0d", i));
    wr(TC_CTRL, 32'h9);
    rd(TC_CTRL, 32'h9, 1'b1, "coll_ctrl");
    rd(TC_COUNT, 32'd0, 1'b1, "coll_load");
    rd(TC_COUNT, 32'd3, 1'b1, "coll_restart");

    step(1'b0, TC_CTRL, 32'h0, 1'b0, 32'h0, 1'b0, "");
    n_total = n_total + 1;
    if (q_d.size() == 0) n_pass = n_pass + 1;
    else $display("FAIL scoreboard_drain: got %0d entries left required 0", q_d.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
